// File: rtl/mux_src_arbiter.sv
// Round-robin arbiter/sequencer for the 10-input, 16-bit source-select mux.
// Grants are bounded by a beat budget; idle cycles park mux_sel on an out-of-range code.
module mux_src_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter logic [3:0]  IDLE_SEL = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  req,
    input  logic        out_ready,
    output logic [3:0]  mux_sel,
    output logic [9:0]  grant,
    output logic        out_valid,
    output logic        beat,
    output logic        expired
);

    localparam logic [7:0] LAST_BEAT = 8'(HOLD_MAX - 1);
    localparam logic [3:0] LAST_IDX  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t      state_r;
    logic [9:0]  grant_r;
    logic [3:0]  sel_r;
    logic        valid_r;
    logic        expired_r;
    logic [7:0]  cnt_r;
    logic [3:0]  ptr_r;

    logic [4:0]  pick_s;
    logic        win_found_s;
    logic [3:0]  win_idx_s;
    logic        owner_req_s;
    logic        beat_s;
    logic        release_s;
    logic        expire_s;

    // Modulo-10 increment; any out-of-range index folds back to 0.
    function automatic logic [3:0] next_idx(input logic [3:0] idx);
        logic [3:0] nxt;
        if (idx >= LAST_IDX) begin
            nxt = 4'd0;
        end else begin
            nxt = idx + 4'd1;
        end
        return nxt;
    endfunction

    // Returns {found, index} of the first set request after 'last', wrapping 9 -> 0.
    function automatic logic [4:0] rr_pick(input logic [9:0] req_v, input logic [3:0] last);
        logic [3:0] idx;
        logic       found;
        logic [3:0] win;
        idx   = last;
        found = 1'b0;
        win   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            idx = next_idx(idx);
            if (!found && req_v[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    function automatic logic [9:0] one_hot(input logic [3:0] idx);
        return 10'd1 << idx;
    endfunction

    // Arbitration winner and grant-exit conditions.
    always_comb begin
        pick_s      = rr_pick(req, ptr_r);
        win_found_s = pick_s[4];
        win_idx_s   = pick_s[3:0];
        owner_req_s = |(req & grant_r);
        beat_s      = valid_r & out_ready;
        // Release takes precedence: expiry requires the owner to still be requesting.
        release_s   = ~owner_req_s;
        expire_s    = beat_s & owner_req_s & (cnt_r == LAST_BEAT);
    end

    // Single state machine holding every registered output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= 10'd0;
            sel_r     <= IDLE_SEL;
            valid_r   <= 1'b0;
            expired_r <= 1'b0;
            cnt_r     <= 8'd0;
            ptr_r     <= LAST_IDX;
        end else begin
            case (state_r)
                ST_IDLE, ST_GAP: begin
                    expired_r <= 1'b0;
                    if (win_found_s) begin
                        state_r <= ST_GRANT;
                        grant_r <= one_hot(win_idx_s);
                        sel_r   <= win_idx_s;
                        valid_r <= 1'b1;
                        cnt_r   <= 8'd0;
                        ptr_r   <= win_idx_s;
                    end else begin
                        state_r <= ST_IDLE;
                        grant_r <= 10'd0;
                        sel_r   <= IDLE_SEL;
                        valid_r <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (release_s || expire_s) begin
                        state_r   <= ST_GAP;
                        grant_r   <= 10'd0;
                        sel_r     <= IDLE_SEL;
                        valid_r   <= 1'b0;
                        expired_r <= expire_s;
                    end else begin
                        expired_r <= 1'b0;
                        if (beat_s) begin
                            cnt_r <= cnt_r + 8'd1;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    grant_r   <= 10'd0;
                    sel_r     <= IDLE_SEL;
                    valid_r   <= 1'b0;
                    expired_r <= 1'b0;
                    cnt_r     <= 8'd0;
                end
            endcase
        end
    end

    assign mux_sel   = sel_r;
    assign grant     = grant_r;
    assign out_valid = valid_r;
    assign expired   = expired_r;
    assign beat      = beat_s;

endmodule

// File: tb/tb_mux_src_arbiter.sv
// Table-driven bench for mux_src_arbiter: one instance with HOLD_MAX=4 runs the vector table,
// a second with HOLD_MAX=2 runs the hand-written stall sequence.
module tb_mux_src_arbiter;

    logic       clk;
    logic       rst_n;
    logic [9:0] req;
    logic       out_ready;

    logic [3:0] mux_sel4, mux_sel2;
    logic [9:0] grant4, grant2;
    logic       out_valid4, out_valid2;
    logic       beat4, beat2;
    logic       expired4, expired2;

    mux_src_arbiter #(.HOLD_MAX(4), .IDLE_SEL(4'hF)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .mux_sel(mux_sel4), .grant(grant4), .out_valid(out_valid4),
        .beat(beat4), .expired(expired4)
    );

    mux_src_arbiter #(.HOLD_MAX(2), .IDLE_SEL(4'hF)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .mux_sel(mux_sel2), .grant(grant2), .out_valid(out_valid2),
        .beat(beat2), .expired(expired2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [9:0] req;
        logic       rdy;
        logic       chk;
        logic [9:0] grant;
        logic [3:0] sel;
        logic       valid;
        logic       beat;
        logic       expired;
    } vec_t;

    typedef struct {
        int         id;
        logic       which;
        logic [9:0] grant;
        logic [3:0] sel;
        logic       valid;
        logic       beat;
        logic       expired;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(input logic r, input logic [9:0] rq, input logic rd, input logic ck,
                                input logic [9:0] g, input logic [3:0] s, input logic v,
                                input logic b, input logic e);
        vec_t t;
        t.rst_n = r; t.req = rq; t.rdy = rd; t.chk = ck;
        t.grant = g; t.sel = s; t.valid = v; t.beat = b; t.expired = e;
        tbl.push_back(t);
    endfunction

    // Drive one cycle of inputs, queue its expectation, then compare against the DUT mid-cycle.
    task automatic run_cycle(input int id, input logic which, input vec_t t);
        exp_t       e;
        logic [9:0] a_grant;
        logic [3:0] a_sel;
        logic       a_valid, a_beat, a_exp;
        rst_n     = t.rst_n;
        req       = t.req;
        out_ready = t.rdy;
        if (t.chk) begin
            e.id = id; e.which = which; e.grant = t.grant; e.sel = t.sel;
            e.valid = t.valid; e.beat = t.beat; e.expired = t.expired;
            sb.push_back(e);
        end
        #1;
        if (t.chk) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty id=%0d", id);
            end else begin
                e = sb.pop_front();
                if (e.which) begin
                    a_grant = grant2; a_sel = mux_sel2; a_valid = out_valid2;
                    a_beat = beat2; a_exp = expired2;
                end else begin
                    a_grant = grant4; a_sel = mux_sel4; a_valid = out_valid4;
                    a_beat = beat4; a_exp = expired4;
                end
                if (a_grant !== e.grant || a_sel !== e.sel || a_valid !== e.valid ||
                    a_beat !== e.beat || a_exp !== e.expired) begin
                    errors++;
                    $display("FAIL %s_vec%0d: got grant=%h sel=%h valid=%b beat=%b expired=%b, need grant=%h sel=%h valid=%b beat=%b expired=%b",
                             e.which ? "stall" : "table", e.id, a_grant, a_sel, a_valid, a_beat, a_exp,
                             e.grant, e.sel, e.valid, e.beat, e.expired);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t t;
        rst_n = 1'b0; req = 10'd0; out_ready = 1'b1;

        // Reset with all requests pending, then first grant goes to index 0.
        add(1'b0, 10'h3FF, 1'b1, 1'b0, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        add(1'b0, 10'h3FF, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        add(1'b0, 10'h3FF, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h3FF, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h3FF, 1'b1, 1'b1, 10'h001, 4'h0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 10'h000, 1'b1, 1'b1, 10'h001, 4'h0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 10'h000, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        // Single requester 3: three beats, then release without expiry.
        add(1'b1, 10'h008, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h008, 1'b1, 1'b1, 10'h008, 4'h3, 1'b1, 1'b1, 1'b0);
        add(1'b1, 10'h008, 1'b1, 1'b1, 10'h008, 4'h3, 1'b1, 1'b1, 1'b0);
        add(1'b1, 10'h000, 1'b1, 1'b1, 10'h008, 4'h3, 1'b1, 1'b1, 1'b0);
        add(1'b1, 10'h000, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h201, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        // Round robin 0,9,0,9 with expiry after 4 beats each.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (k % 2 == 0) add(1'b1, 10'h201, 1'b1, 1'b1, 10'h001, 4'h0, 1'b1, 1'b1, 1'b0);
                else            add(1'b1, 10'h201, 1'b1, 1'b1, 10'h200, 4'h9, 1'b1, 1'b1, 1'b0);
            end
            add(1'b1, (k == 3) ? 10'h104 : 10'h201, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b1);
        end
        // Wrap 9 -> 2, then 8; bit 8 drops on its last beat so release wins.
        for (int j = 0; j < 4; j++) add(1'b1, 10'h104, 1'b1, 1'b1, 10'h004, 4'h2, 1'b1, 1'b1, 1'b0);
        add(1'b1, 10'h104, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) add(1'b1, 10'h104, 1'b1, 1'b1, 10'h100, 4'h8, 1'b1, 1'b1, 1'b0);
        add(1'b1, 10'h004, 1'b1, 1'b1, 10'h100, 4'h8, 1'b1, 1'b1, 1'b0);
        add(1'b1, 10'h004, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h000, 1'b1, 1'b1, 10'h004, 4'h2, 1'b1, 1'b1, 1'b0);
        // Grant to 6, reset mid-grant, pointer restarts so 0 beats 6.
        add(1'b1, 10'h040, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h040, 1'b1, 1'b1, 10'h040, 4'h6, 1'b1, 1'b1, 1'b0);
        add(1'b0, 10'h040, 1'b1, 1'b1, 10'h040, 4'h6, 1'b1, 1'b1, 1'b0);
        add(1'b1, 10'h041, 1'b1, 1'b1, 10'h000, 4'hF, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h041, 1'b1, 1'b1, 10'h001, 4'h0, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(i, 1'b0, tbl[i]);
        end

        // Stall on the HOLD_MAX=2 instance: ready 1,0,0,1 -> 4-cycle grant, 2 beats, expiry.
        t.chk = 1'b0; t.rst_n = 1'b0; t.req = 10'h020; t.rdy = 1'b1;
        t.grant = 10'h000; t.sel = 4'hF; t.valid = 1'b0; t.beat = 1'b0; t.expired = 1'b0;
        run_cycle(0, 1'b1, t);
        t.chk = 1'b1; t.rst_n = 1'b1;
        run_cycle(1, 1'b1, t);
        t.grant = 10'h020; t.sel = 4'h5; t.valid = 1'b1; t.beat = 1'b1;
        run_cycle(2, 1'b1, t);
        t.rdy = 1'b0; t.beat = 1'b0;
        run_cycle(3, 1'b1, t);
        run_cycle(4, 1'b1, t);
        t.rdy = 1'b1; t.beat = 1'b1;
        run_cycle(5, 1'b1, t);
        t.grant = 10'h000; t.sel = 4'hF; t.valid = 1'b0; t.beat = 1'b0; t.expired = 1'b1;
        run_cycle(6, 1'b1, t);
        t.grant = 10'h020; t.sel = 4'h5; t.valid = 1'b1; t.beat = 1'b1; t.expired = 1'b0;
        run_cycle(7, 1'b1, t);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, need 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
